// File: rtl/counter_pkg.sv
// Shared types and default widths for the counter bank and its read collector.
package counter_pkg;

   localparam int DEF_N       = 10;
   localparam int DEF_G       = 4;
   localparam int DEF_MAXW    = 32;
   localparam int DEF_TIMEOUT = 16;
   localparam int ID_W        = $clog2(DEF_N);

   typedef enum logic [2:0] {
      CMD_IDLE      = 3'b000,
      CMD_INCREMENT = 3'b001,
      CMD_NEW       = 3'b010,
      CMD_DEALLOC   = 3'b011,
      CMD_LOAD      = 3'b100,
      CMD_READ      = 3'b101
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_RESP    = 2'd2
   } coll_state_t;

endpackage

// File: rtl/counter_read_collector_chunk_assembler.sv
// Places G-bit chunks into a MAXW-bit register, least significant chunk first,
// counting chunks (saturating at MAXC+1) and flagging chunks beyond MAXC.
module chunk_assembler #(
   parameter int G    = 4,
   parameter int MAXW = 32,
   localparam int MAXC = MAXW / G,
   localparam int CW   = $clog2(MAXC) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_clear,
   input  logic            i_push,
   input  logic [G-1:0]    i_data,
   output logic [MAXW-1:0] o_value,
   output logic [CW-1:0]   o_chunks,
   output logic            o_overflow
);

   logic [MAXW-1:0] r_value;
   logic [CW-1:0]   r_count;
   logic            r_overflow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_value    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_clear) begin
         r_value    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_push) begin
         if (r_count < CW'(MAXC)) begin
            for (int k = 0; k < MAXC; k++) begin
               if (r_count == CW'(k)) r_value[k*G +: G] <= i_data;
            end
            r_count <= r_count + 1'b1;
         end else begin
            // Excess chunks are dropped; the count stops one past MAXC.
            r_overflow <= 1'b1;
            if (r_count != CW'(MAXC + 1)) r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_value    = r_value;
   assign o_chunks   = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/counter_read_collector.sv
// Issues READ to the counter bank and reassembles its chunked reply into one value.
// Optional abort-on-silence timer: define COUNTER_READ_TIMEOUT_EN.
module counter_read_collector
   import counter_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int G       = DEF_G,
   parameter int MAXW    = DEF_MAXW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [$clog2(N)-1:0]              req_id,
   output logic [2:0]                        sc_command,
   output logic [$clog2(N)-1:0]              sc_id,
   input  logic [G-1:0]                      sc_rdata,
   input  logic                              sc_valid,
   input  logic                              sc_last,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [$clog2(N)-1:0]              rsp_id,
   output logic [MAXW-1:0]                   rsp_value,
   output logic [$clog2(MAXW/G):0]           rsp_chunks,
   output logic                              rsp_overflow,
   output logic                              rsp_timeout
);

   localparam int IDW = $clog2(N);

   coll_state_t    r_state;
   coll_state_t    w_next;
   logic [IDW-1:0] r_id;
   logic           w_accept;
   logic           w_push;
   logic           w_tmo;

   assign w_accept = (r_state == ST_IDLE) && req_valid;
   assign w_push   = (r_state == ST_COLLECT) && sc_valid;

`ifdef COUNTER_READ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_timer;
   logic          r_timeout;

   // A chunk arriving on the expiry cycle wins over the timeout.
   assign w_tmo = (r_state == ST_COLLECT) && !sc_valid && (r_timer == TW'(TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timer   <= '0;
         r_timeout <= 1'b0;
      end else if (w_accept) begin
         r_timer   <= '0;
         r_timeout <= 1'b0;
      end else if (r_state == ST_COLLECT) begin
         if (sc_valid)                        r_timer <= '0;
         else if (r_timer != TW'(TIMEOUT))    r_timer <= r_timer + 1'b1;
         if (w_tmo)                           r_timeout <= 1'b1;
      end
   end

   assign rsp_timeout = r_timeout;
`else
   assign w_tmo       = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_id    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) r_id <= req_id;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (req_valid) w_next = ST_COLLECT;
         ST_COLLECT: if ((sc_valid && sc_last) || w_tmo) w_next = ST_RESP;
         ST_RESP:    if (rsp_ready) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Outputs decode the state register only, so no input reaches an output combinationally.
   assign req_ready  = (r_state == ST_IDLE);
   assign rsp_valid  = (r_state == ST_RESP);
   assign sc_command = (r_state == ST_COLLECT) ? CMD_READ : CMD_IDLE;
   assign sc_id      = r_id;
   assign rsp_id     = r_id;

   chunk_assembler #(
      .G    (G),
      .MAXW (MAXW)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_accept),
      .i_push     (w_push),
      .i_data     (sc_rdata),
      .o_value    (rsp_value),
      .o_chunks   (rsp_chunks),
      .o_overflow (rsp_overflow)
   );

endmodule
